// File: rtl/cpu_pkg.sv
// Shared CPU constants: supported opcodes, the NOP instruction word and the fetch FSM state type.
// Purely declarative; no latency and no backpressure.
package cpu_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    function automatic logic is_supported_op(input logic [6:0] op);
        case (op)
            OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG: is_supported_op = 1'b1;
            default:                  is_supported_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus: the fetch unit is master, the memory is slave.
// No storage of its own; the slave holds off the master by delaying im_ack.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            im_req;
    logic [XLEN-1:0] im_addr;
    logic            im_ack;
    logic [XLEN-1:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_imm_gen.sv
// Immediate generator: sign-extended I/S/B/J immediate selected by the opcode in IR.
// Purely combinational, zero latency, no backpressure.
module imm_gen
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] IR,
    output logic [XLEN-1:0] IMM
);

    always_comb begin
        IMM = '0;
        case (IR[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                IMM = {{(XLEN-12){IR[31]}}, IR[31:20]};
            OP_STORE:
                IMM = {{(XLEN-12){IR[31]}}, IR[31:25], IR[11:7]};
            OP_BRANCH:
                IMM = {{(XLEN-13){IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
            OP_JAL:
                IMM = {{(XLEN-21){IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
            default:
                IMM = '0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: req/ack fetch of the word at PC into IR, then field/immediate decode; IR ready 2 edges after IMRead.
// Memory stalls by withholding im_ack (fetch_busy held); FETCH_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              TIMEOUT_CYCLES = 16,
    parameter logic [XLEN-1:0] NOP_WORD       = cpu_pkg::NOP_WORD
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [XLEN-1:0]     PC,
    input  logic                IMRead,
    input  logic                IRWrite,
    instr_fetch_unit_if.master  im,
    output logic [XLEN-1:0]     IR,
    output logic [6:0]          OPCODE,
    output logic [2:0]          func3,
    output logic [6:0]          func7,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     IMM,
    output logic                fetch_busy,
    output logic                fetch_valid,
    output logic                illegal,
    output logic                fetch_err
);

    fetch_state_t    state;
    logic            im_req_q;
    logic [XLEN-1:0] im_addr_q;
    logic [XLEN-1:0] ir_q;
    logic            ir_wr_q;
    logic            fetch_valid_q;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
    logic       fetch_err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    logic [1:0] unused_pc_lsb;
    assign unused_pc_lsb = PC[1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            im_req_q      <= 1'b0;
            im_addr_q     <= '0;
            ir_q          <= NOP_WORD;
            ir_wr_q       <= 1'b0;
            fetch_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt      <= '0;
            fetch_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A late ack landing here belongs to no request and is dropped.
                    if (IMRead) begin
                        im_addr_q     <= {PC[XLEN-1:2], 2'b00};
                        ir_wr_q       <= IRWrite;
                        im_req_q      <= 1'b1;
                        fetch_valid_q <= 1'b0;
                        state         <= REQ;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt      <= '0;
                        fetch_err_q   <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (im.im_ack) begin
                        if (ir_wr_q) begin
                            ir_q <= im.im_rdata;
                        end
                        im_req_q      <= 1'b0;
                        fetch_valid_q <= 1'b1;
                        state         <= IDLE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Ack takes priority over the abort when both land on the same edge.
                    else if (wait_cnt == WAIT_LAST) begin
                        ir_q          <= NOP_WORD;
                        im_req_q      <= 1'b0;
                        fetch_valid_q <= 1'b1;
                        fetch_err_q   <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign im.im_req    = im_req_q;
    assign im.im_addr   = im_addr_q;
    assign IR           = ir_q;
    assign fetch_valid  = fetch_valid_q;
    assign fetch_busy   = (state == REQ) | ((state == IDLE) & IMRead);

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign OPCODE  = ir_q[6:0];
    assign rd      = ir_q[11:7];
    assign func3   = ir_q[14:12];
    assign rs1     = ir_q[19:15];
    assign rs2     = ir_q[24:20];
    assign func7   = ir_q[31:25];
    assign illegal = ~is_supported_op(ir_q[6:0]);

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .IR  (ir_q),
        .IMM (IMM)
    );

endmodule
